// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single instruction-memory port between the
// fetch unit (read-only) and the loader/debug port (read/write). Round-robin
// grant, one registered response slot per requester, address-checked accesses.
module imem_port_arbiter #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int MEM_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 f_req_valid,
  output logic                 f_req_ready,
  input  logic [ADDRWIDTH-1:0] f_req_addr,
  output logic                 f_rsp_valid,
  input  logic                 f_rsp_ready,
  output logic [DATAWIDTH-1:0] f_rsp_data,
  output logic                 f_rsp_err,
  input  logic                 l_req_valid,
  output logic                 l_req_ready,
  input  logic [ADDRWIDTH-1:0] l_req_addr,
  input  logic                 l_req_we,
  input  logic [DATAWIDTH-1:0] l_req_wdata,
  output logic                 l_rsp_valid,
  input  logic                 l_rsp_ready,
  output logic [DATAWIDTH-1:0] l_rsp_data,
  output logic                 l_rsp_err,
  output logic [ADDRWIDTH-1:0] mem_address,
  output logic                 mem_read_write,
  output logic [DATAWIDTH-1:0] mem_data_in,
  input  logic [DATAWIDTH-1:0] mem_data_out
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rsp_state_e;

  // Highest byte address at which a whole word still fits in memory.
  localparam logic [ADDRWIDTH-1:0] LAST_WORD = ADDRWIDTH'(MEM_DEPTH - 4);

  rsp_state_e             f_state_q, f_state_d, l_state_q, l_state_d;
  logic [DATAWIDTH-1:0]   f_data_q, f_data_d, l_data_q, l_data_d;
  logic                   f_err_q, f_err_d, l_err_q, l_err_d;
  logic                   last_l_q, last_l_d;  // 1 = loader granted most recently

  logic                   f_elig, l_elig, gnt_f, gnt_l, any_gnt, addr_err;
  logic [ADDRWIDTH-1:0]   sel_addr;
  logic [DATAWIDTH-1:0]   rd_word;

  // Eligibility, round-robin grant, address check and memory port drive.
  // Grants are suppressed while reset is asserted so no write can slip out.
  always_comb begin
    f_elig   = f_req_valid && (f_state_q == EMPTY || f_rsp_ready);
    l_elig   = l_req_valid && (l_state_q == EMPTY || l_rsp_ready);
    gnt_f    = rst_n && f_elig && (!l_elig || last_l_q);
    gnt_l    = rst_n && l_elig && (!f_elig || !last_l_q);
    any_gnt  = gnt_f || gnt_l;
    sel_addr = gnt_l ? l_req_addr : f_req_addr;
    addr_err = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
    mem_address    = (any_gnt && !addr_err) ? sel_addr : '0;
    mem_read_write = gnt_l && !addr_err && l_req_we;
    mem_data_in    = (any_gnt && !addr_err) ? l_req_wdata : '0;
    // Writes and rejected accesses return zero data.
    rd_word  = (addr_err || (gnt_l && l_req_we)) ? '0 : mem_data_out;
    f_req_ready = gnt_f;
    l_req_ready = gnt_l;
  end

  // Next state of both response slots and the last-grant pointer.
  always_comb begin
    f_state_d = f_state_q;
    l_state_d = l_state_q;
    case (f_state_q)
      EMPTY:   if (gnt_f) f_state_d = FULL;
      default: if (f_rsp_ready && !gnt_f) f_state_d = EMPTY;
    endcase
    case (l_state_q)
      EMPTY:   if (gnt_l) l_state_d = FULL;
      default: if (l_rsp_ready && !gnt_l) l_state_d = EMPTY;
    endcase
    f_data_d = gnt_f ? rd_word  : f_data_q;
    f_err_d  = gnt_f ? addr_err : f_err_q;
    l_data_d = gnt_l ? rd_word  : l_data_q;
    l_err_d  = gnt_l ? addr_err : l_err_q;
    last_l_d = gnt_l ? 1'b1 : (gnt_f ? 1'b0 : last_l_q);
  end

  // State register; reset empties both slots and points last grant at loader.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_state_q <= EMPTY;
      l_state_q <= EMPTY;
      f_data_q  <= '0;
      l_data_q  <= '0;
      f_err_q   <= 1'b0;
      l_err_q   <= 1'b0;
      last_l_q  <= 1'b1;
    end else begin
      f_state_q <= f_state_d;
      l_state_q <= l_state_d;
      f_data_q  <= f_data_d;
      l_data_q  <= l_data_d;
      f_err_q   <= f_err_d;
      l_err_q   <= l_err_d;
      last_l_q  <= last_l_d;
    end
  end

  // Response outputs come straight from registers.
  always_comb begin
    f_rsp_valid = (f_state_q == FULL);
    l_rsp_valid = (l_state_q == FULL);
    f_rsp_data  = f_data_q;
    f_rsp_err   = f_err_q;
    l_rsp_data  = l_data_q;
    l_rsp_err   = l_err_q;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a 32-byte behavioural memory.
module tb_imem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [31:0] f_req_addr, f_rsp_data;
  logic        l_req_valid, l_req_ready, l_req_we, l_rsp_valid, l_rsp_ready, l_rsp_err;
  logic [31:0] l_req_addr, l_req_wdata, l_rsp_data;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:7];
  logic [31:0] exp_words [0:7];

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDRWIDTH(32), .DATAWIDTH(32), .MEM_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .f_rsp_err(f_rsp_err),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_addr(l_req_addr),
    .l_req_we(l_req_we), .l_req_wdata(l_req_wdata),
    .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready), .l_rsp_data(l_rsp_data),
    .l_rsp_err(l_rsp_err),
    .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Combinational-read, clocked-write memory.
  assign mem_data_out = mem[mem_address[4:2]];
  always @(posedge clk) if (mem_read_write) mem[mem_address[4:2]] <= mem_data_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    exp_words[0] = 32'h00940333; exp_words[1] = 32'h10000001;
    exp_words[2] = 32'h10000002; exp_words[3] = 32'h10000003;
    exp_words[4] = 32'h10000004; exp_words[5] = 32'h10000005;
    exp_words[6] = 32'h10000006; exp_words[7] = 32'hCAFEF00D;

    rst_n = 1'b0;
    f_req_valid = 0; f_req_addr = 0; f_rsp_ready = 1;
    l_req_valid = 1; l_req_we = 1; l_req_addr = 32'h4; l_req_wdata = 32'hDEADBEEF; l_rsp_ready = 1;

    // Reset with a pending loader write: nothing issued.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_l_req_ready", {31'b0, l_req_ready}, 0);
      chk("rst_mem_rw", {31'b0, mem_read_write}, 0);
    end
    tick();
    l_req_valid = 0; rst_n = 1'b1; #1;
    chk("rst_f_rsp_valid", {31'b0, f_rsp_valid}, 0);
    chk("rst_l_rsp_valid", {31'b0, l_rsp_valid}, 0);
    chk("rst_l_rsp_data", l_rsp_data, 0);
    chk("rst_no_write", mem[1], 0);

    // Loader write of word 0.
    l_req_valid = 1; l_req_we = 1; l_req_addr = 32'h0; l_req_wdata = 32'h00940333; #1;
    chk("lw_ready", {31'b0, l_req_ready}, 1);
    chk("lw_mem_rw", {31'b0, mem_read_write}, 1);
    tick();
    l_req_valid = 0;
    chk("lw_rsp_valid", {31'b0, l_rsp_valid}, 1);
    chk("lw_rsp_data", l_rsp_data, 0);
    chk("lw_mem0", mem[0], 32'h00940333);

    // Fetch read of word 0.
    f_req_valid = 1; f_req_addr = 32'h0; #1;
    chk("fr_ready", {31'b0, f_req_ready}, 1);
    tick();
    f_req_valid = 0;
    chk("fr_rsp_valid", {31'b0, f_rsp_valid}, 1);
    chk("fr_rsp_data", f_rsp_data, 32'h00940333);

    // Preload words 1..6 back-to-back.
    for (int i = 1; i < 7; i++) begin
      l_req_valid = 1; l_req_we = 1; l_req_addr = 4 * i; l_req_wdata = 32'h10000000 + i; #1;
      chk("pre_ready", {31'b0, l_req_ready}, 1);
      tick();
      chk("pre_rsp_valid", {31'b0, l_rsp_valid}, 1);
    end
    l_req_valid = 0; l_req_we = 0;
    tick();

    // Contention: grants alternate F, L, F, L.
    for (int k = 0; k < 4; k++) begin
      f_req_valid = 1; l_req_valid = 1; f_req_addr = 4 * k; l_req_addr = 4 * k; #1;
      chk("ct_f_ready", {31'b0, f_req_ready}, (k % 2 == 0) ? 1 : 0);
      chk("ct_l_ready", {31'b0, l_req_ready}, (k % 2 == 1) ? 1 : 0);
      tick();
      if (k % 2 == 0) begin
        chk("ct_f_valid", {31'b0, f_rsp_valid}, 1);
        chk("ct_f_data", f_rsp_data, exp_words[k]);
      end else begin
        chk("ct_l_valid", {31'b0, l_rsp_valid}, 1);
        chk("ct_l_data", l_rsp_data, exp_words[k]);
      end
    end
    f_req_valid = 0; l_req_valid = 0;
    tick();

    // Backpressure on fetch while the loader is served.
    f_req_valid = 1; f_req_addr = 32'h8; f_rsp_ready = 0; #1;
    chk("bp_accept", {31'b0, f_req_ready}, 1);
    tick();
    f_req_addr = 32'h10;
    l_req_valid = 1; l_req_we = 0; l_req_addr = 32'hC;
    for (int h = 0; h < 3; h++) begin
      #1;
      chk("bp_f_ready", {31'b0, f_req_ready}, 0);
      if (h == 0) chk("bp_l_ready", {31'b0, l_req_ready}, 1);
      tick();
      if (h == 0) begin
        l_req_valid = 0;
        chk("bp_l_valid", {31'b0, l_rsp_valid}, 1);
        chk("bp_l_data", l_rsp_data, 32'h10000003);
      end
      chk("bp_f_valid", {31'b0, f_rsp_valid}, 1);
      chk("bp_f_data", f_rsp_data, 32'h10000002);
    end
    f_req_valid = 0; f_rsp_ready = 1;
    tick();
    chk("bp_drain", {31'b0, f_rsp_valid}, 0);

    // Misaligned fetch.
    f_req_valid = 1; f_req_addr = 32'h2; #1;
    chk("err_f_mem_rw", {31'b0, mem_read_write}, 0);
    tick();
    f_req_valid = 0;
    chk("err_f_err", {31'b0, f_rsp_err}, 1);
    chk("err_f_data", f_rsp_data, 0);

    // Last valid word, then out of range.
    l_req_valid = 1; l_req_we = 1; l_req_addr = 32'h1C; l_req_wdata = 32'hCAFEF00D; #1;
    tick();
    chk("err_l1c_err", {31'b0, l_rsp_err}, 0);
    chk("err_l1c_mem", mem[7], 32'hCAFEF00D);
    l_req_addr = 32'h20; l_req_wdata = 32'hBAD0BAD0; #1;
    chk("err_l20_ready", {31'b0, l_req_ready}, 1);
    chk("err_l20_mem_rw", {31'b0, mem_read_write}, 0);
    tick();
    l_req_valid = 0; l_req_we = 0;
    chk("err_l20_err", {31'b0, l_rsp_err}, 1);
    chk("err_l20_data", l_rsp_data, 0);
    chk("err_l20_mem7", mem[7], 32'hCAFEF00D);
    chk("err_l20_mem0", mem[0], 32'h00940333);

    // Back-to-back fetch sweep.
    for (int i = 0; i < 8; i++) begin
      f_req_valid = 1; f_req_addr = 4 * i; #1;
      chk("b2b_ready", {31'b0, f_req_ready}, 1);
      tick();
      chk("b2b_valid", {31'b0, f_rsp_valid}, 1);
      chk("b2b_err", {31'b0, f_rsp_err}, 0);
      chk("b2b_data", f_rsp_data, exp_words[i]);
    end
    f_req_valid = 0;

    // Reset while a fetch response is held; the pending write is dropped.
    f_rsp_ready = 0; f_req_valid = 1; f_req_addr = 32'h4; #1;
    tick();
    f_req_valid = 0;
    chk("mr_held", {31'b0, f_rsp_valid}, 1);
    rst_n = 0; l_req_valid = 1; l_req_we = 1; l_req_addr = 32'h8; l_req_wdata = 32'h0BADF00D; #1;
    chk("mr_mem_rw", {31'b0, mem_read_write}, 0);
    tick();
    rst_n = 1; l_req_valid = 0; l_req_we = 0;
    chk("mr_f_valid", {31'b0, f_rsp_valid}, 0);
    chk("mr_f_data", f_rsp_data, 0);
    chk("mr_no_write", mem[2], 32'h10000002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
